mem_ctrl: RTL and testbench

Memory controller between the `riscv` core and a single byte-wide synchronous external RAM. It serves two request ports: instruction fetch (the core's PC side) and data load/store (the core's MEM side). Each access is serialised into 1–4 byte transfers. Returned bytes are assembled little-endian into a 32-bit word, and completion is reported with a one-cycle ready pulse.

---
 rtl/mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises core fetch and data accesses onto one byte-wide synchronous RAM,
// assembling returned bytes little-endian and reporting completion with a one-cycle ready pulse.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_abort,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_len,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic [7:0]        mem_din,
    output logic [2:0]        dbg_state
);

    // Handshake: a requester raises if_req or d_re/d_we with stable address/data and holds
    // them until the matching ready pulses (or, for fetch, until it aborts); the request is
    // only sampled while idle, and the requester drops it during its ready cycle.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DREAD  = 3'd2,
        DWRITE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [2:0]        n;
    logic [2:0]        k;
    logic [2:0]        k_next;
    logic [31:0]       wbuf;
    logic [31:0]       rbuf;
    logic [31:0]       assembled;
    logic [1:0]        lane;
    logic              port_fetch;

    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    assign dbg_state = state;

    // RAM data arrives one cycle after its address, so cycle k fills lane k-1.
    always_comb begin
        k_next    = k + 3'd1;
        lane      = 2'(k - 3'd1);
        assembled = rbuf;
        assembled[{lane, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            base       <= '0;
            n          <= 3'd0;
            k          <= 3'd0;
            wbuf       <= '0;
            rbuf       <= '0;
            port_fetch <= 1'b0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            if_data    <= '0;
            d_rdata    <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    mem_wr <= 1'b0;
                    k      <= 3'd0;
                    rbuf   <= '0;
                    if (d_we) begin
                        base       <= d_addr;
                        n          <= len_to_n(d_len);
                        wbuf       <= d_wdata;
                        port_fetch <= 1'b0;
                        mem_a      <= d_addr;
                        mem_dout   <= d_wdata[7:0];
                        mem_wr     <= 1'b1;
                        state      <= DWRITE;
                    end else if (d_re) begin
                        base       <= d_addr;
                        n          <= len_to_n(d_len);
                        port_fetch <= 1'b0;
                        mem_a      <= d_addr;
                        state      <= DREAD;
                    end else if (if_req) begin
                        base       <= if_addr;
                        n          <= 3'd4;
                        port_fetch <= 1'b1;
                        mem_a      <= if_addr;
                        state      <= FETCH;
                    end
                end
                FETCH, DREAD: begin
                    if (state == FETCH && if_abort) begin
                        state <= IDLE;
                    end else begin
                        if (k != 3'd0) begin
                            rbuf <= assembled;
                        end
                        if (k_next < n) begin
                            mem_a <= base + ADDR_W'(k_next);
                        end
                        if (k == n) begin
                            state <= DONE;
                            if (port_fetch) begin
                                if_ready <= 1'b1;
                                if_data  <= assembled;
                            end else begin
                                d_ready <= 1'b1;
                                d_rdata <= assembled;
                            end
                        end
                        k <= k_next;
                    end
                end
                DWRITE: begin
                    if (k_next < n) begin
                        mem_a    <= base + ADDR_W'(k_next);
                        mem_dout <= byte_sel(wbuf, k_next[1:0]);
                        k        <= k_next;
                    end else begin
                        mem_wr  <= 1'b0;
                        d_ready <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    mem_wr <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    mem_wr <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios plus two randomized requester ports, checked every cycle
// against a transaction-level schedule model and a byte-addressed reference memory.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_abort = 1'b0;
    logic        if_ready;
    logic [31:0] if_data;
    logic        d_re = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [1:0]  d_len = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din = '0;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
        .if_ready(if_ready), .if_data(if_data),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // ---------------- RAM contents and external RAM ----------------
    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            32'h200: return 8'h11;
            32'h201: return 8'h22;
            32'h202: return 8'h33;
            32'h203: return 8'h44;
            32'h020: return 8'hFF;
            32'h021: return 8'h80;
            32'h022: return 8'h77;
            32'h080: return 8'h6F;
            32'h081: return 8'h00;
            32'h082: return 8'h00;
            32'h083: return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    logic [7:0] ram [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        mem_din <= ram_byte(mem_a);
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no ready within cycle budget at %0t", name, $time);
    endtask

    // ---------------- behavioural model: per-cycle expected schedule ----------------
    typedef struct packed {
        logic        if_rdy;
        logic        d_rdy;
        logic        wr;
        logic        abortable;
        logic [31:0] a;
        logic [7:0]  dout;
        logic [31:0] if_dat;
        logic [31:0] d_dat;
    } cyc_t;
    localparam int W = $bits(cyc_t);

    logic [W-1:0] exp_q[$];
    logic [31:0]  last_a = '0;
    logic [31:0]  held_if = '0;
    logic [31:0]  held_d = '0;

    function automatic int len_n(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    task automatic sched_read(input logic [31:0] a, input int n, input logic fetch);
        cyc_t r;
        logic [31:0] word;
        word = '0;
        for (int i = 0; i < n; i++) word[8*i +: 8] = ref_byte(a + 32'(i));
        for (int c = 0; c <= n + 1; c++) begin
            r = '0;
            r.a = a + 32'((c < n) ? c : n - 1);
            r.if_dat = held_if;
            r.d_dat = held_d;
            if (c <= n) r.abortable = fetch;
            else if (fetch) begin
                r.if_rdy = 1'b1;
                r.if_dat = word;
            end else begin
                r.d_rdy = 1'b1;
                r.d_dat = word;
            end
            exp_q.push_back(r);
        end
    endtask

    task automatic sched_write(input logic [31:0] a, input int n, input logic [31:0] wd);
        cyc_t r;
        for (int c = 0; c <= n; c++) begin
            r = '0;
            r.if_dat = held_if;
            r.d_dat = held_d;
            if (c < n) begin
                r.a = a + 32'(c);
                r.wr = 1'b1;
                r.dout = wd[8*c +: 8];
            end else begin
                r.a = a + 32'(n - 1);
                r.d_rdy = 1'b1;
            end
            exp_q.push_back(r);
        end
    endtask

    always @(posedge clk or negedge rst) begin : model
        cyc_t r;
        if (!rst) begin
            exp_q.delete();
            last_a = '0;
            held_if = '0;
            held_d = '0;
        end else if (exp_q.size() == 0) begin
            if (d_we) sched_write(d_addr, len_n(d_len), d_wdata);
            else if (d_re) sched_read(d_addr, len_n(d_len), 1'b0);
            else if (if_req) sched_read(if_addr, 4, 1'b1);
        end else begin
            r = cyc_t'(exp_q.pop_front());
            last_a = r.a;
            held_if = r.if_dat;
            held_d = r.d_dat;
            if (r.wr) ref_mem[r.a] = r.dout;
            if (r.abortable && if_abort) exp_q.delete();
        end
    end

    always @(negedge clk) begin : compare
        cyc_t e;
        if (!rst) begin
            chk("rst_if_ready", 32'(if_ready), 32'd0);
            chk("rst_d_ready", 32'(d_ready), 32'd0);
            chk("rst_mem_wr", 32'(mem_wr), 32'd0);
            chk("rst_mem_a", mem_a, 32'd0);
        end else begin
            if (exp_q.size() > 0) e = cyc_t'(exp_q[0]);
            else begin
                e = '0;
                e.a = last_a;
                e.if_dat = held_if;
                e.d_dat = held_d;
            end
            chk("if_ready", 32'(if_ready), 32'(e.if_rdy));
            chk("d_ready", 32'(d_ready), 32'(e.d_rdy));
            chk("mem_wr", 32'(mem_wr), 32'(e.wr));
            chk("mem_a", mem_a, e.a);
            if (e.wr) chk("mem_dout", 32'(mem_dout), 32'(e.dout));
            chk("if_data", if_data, e.if_dat);
            chk("d_rdata", d_rdata, e.d_dat);
        end
    end

    // ---------------- random drivers ----------------
    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return 32'h300 + 32'($urandom_range(0, 63));
            1: return 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            2: return $urandom();
            default: return 32'h300 + 32'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic fetch_port(input int ops);
        int abort_at;
        bit got;
        for (int i = 0; i < ops; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            if_addr = rand_addr();
            if_req = 1'b1;
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            got = 1'b0;
            for (int c = 1; c <= 40 && !got; c++) begin
                @(negedge clk);
                if (if_ready) got = 1'b1;
                else if (c == abort_at) begin
                    if_abort = 1'b1;
                    if_req = 1'b0;
                    @(negedge clk);
                    if_abort = 1'b0;
                    got = 1'b1;
                end
            end
            if (!got) timeout_fail("fetch_timeout");
            if_req = 1'b0;
        end
    endtask

    task automatic data_port(input int ops);
        bit got;
        for (int i = 0; i < ops; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            d_addr = rand_addr();
            d_len = 2'($urandom_range(0, 3));
            d_wdata = $urandom();
            if ($urandom_range(0, 1) == 1) d_we = 1'b1;
            else d_re = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                if (d_ready) got = 1'b1;
            end
            if (!got) timeout_fail("data_timeout");
            d_we = 1'b0;
            d_re = 1'b0;
        end
    endtask

    // ---------------- directed scenarios, then random traffic ----------------
    logic [7:0]  wb [4];
    logic [31:0] wa [4];
    int          n;

    initial begin
        wb[0] = 8'hDD; wb[1] = 8'hCC; wb[2] = 8'hBB; wb[3] = 8'hAA;
        wa[0] = 32'hFFFFFFFE; wa[1] = 32'hFFFFFFFF; wa[2] = 32'h0; wa[3] = 32'h1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_if_data", if_data, 32'd0);
        chk("reset_d_rdata", d_rdata, 32'd0);
        chk("reset_mem_dout", 32'(mem_dout), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'd0);
        rst = 1'b1;

        // word fetch at 0x100
        if_addr = 32'h100;
        if_req = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c < 4) chk("fetch_addr_seq", mem_a, 32'h100 + 32'(c));
            chk("fetch_ready_cycle", 32'(if_ready), 32'(c == 5));
            if (c == 5) begin
                chk("fetch_word", if_data, 32'h00100513);
                if_req = 1'b0;
            end
        end
        @(negedge clk);

        // simultaneous fetch and data read: data first, fetch two cycles after d_ready
        if_addr = 32'h0;
        if_req = 1'b1;
        d_addr = 32'h200;
        d_len = 2'd2;
        d_re = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            chk("arb_d_ready", 32'(d_ready), 32'(c == 5));
            chk("arb_if_ready", 32'(if_ready), 32'(c == 12));
            if (c == 5) begin
                chk("arb_d_rdata", d_rdata, 32'h44332211);
                d_re = 1'b0;
            end
            if (c == 7) begin
                chk("arb_fetch_start_addr", mem_a, 32'h0);
                chk("arb_fetch_state", 32'(dbg_state), 32'd1);
            end
            if (c == 12) if_req = 1'b0;
        end
        @(negedge clk);

        // stores of each size at 0x10
        for (int l = 0; l < 3; l++) begin
            n = (l == 0) ? 1 : (l == 1) ? 2 : 4;
            d_addr = 32'h10;
            d_wdata = 32'hAABBCCDD;
            d_len = 2'(l);
            d_we = 1'b1;
            for (int c = 0; c <= n; c++) begin
                @(negedge clk);
                chk("store_wr", 32'(mem_wr), 32'(c < n));
                chk("store_ready", 32'(d_ready), 32'(c == n));
                if (c < n) begin
                    chk("store_addr", mem_a, 32'h10 + 32'(c));
                    chk("store_byte", 32'(mem_dout), 32'(wb[c]));
                end else d_we = 1'b0;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) chk("store_ram", 32'(ram_byte(32'h10 + 32'(i))), 32'(wb[i]));

        // half load with zero-extension
        d_addr = 32'h20;
        d_len = 2'd1;
        d_re = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            chk("half_ready", 32'(d_ready), 32'(c == 3));
            if (c == 3) begin
                chk("half_data", d_rdata, 32'h000080FF);
                d_re = 1'b0;
            end
        end
        @(negedge clk);

        // abort a fetch in cycle 2, then a new fetch at 0x80
        if_addr = 32'h40;
        if_req = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            chk("abort_if_ready", 32'(if_ready), 32'(c == 9));
            if (c == 0) chk("abort_fetch_state", 32'(dbg_state), 32'd1);
            if (c == 2) if_abort = 1'b1;
            if (c == 3) begin
                chk("abort_idle_state", 32'(dbg_state), 32'd0);
                if_abort = 1'b0;
                if_addr = 32'h80;
            end
            if (c == 4) begin
                chk("abort_new_addr", mem_a, 32'h80);
                chk("abort_new_state", 32'(dbg_state), 32'd1);
            end
            if (c == 9) begin
                chk("abort_new_word", if_data, 32'h0000006F);
                if_req = 1'b0;
            end
        end
        @(negedge clk);

        // reset in the middle of a word store, after two bytes
        d_addr = 32'h50;
        d_wdata = 32'h11223344;
        d_len = 2'd2;
        d_we = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
        chk("midrst_mem_a", mem_a, 32'd0);
        chk("midrst_mem_dout", 32'(mem_dout), 32'd0);
        chk("midrst_state", 32'(dbg_state), 32'd0);
        chk("midrst_d_ready", 32'(d_ready), 32'd0);
        chk("midrst_if_data", if_data, 32'd0);
        chk("midrst_d_rdata", d_rdata, 32'd0);
        d_we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_byte0", 32'(ram_byte(32'h50)), 32'h44);
        chk("midrst_byte1", 32'(ram_byte(32'h51)), 32'h33);
        chk("midrst_byte2", 32'(ram_byte(32'h52)), 32'(init_byte(32'h52)));
        @(negedge clk);

        // word read wrapping past the top of the address space
        d_addr = 32'hFFFFFFFE;
        d_len = 2'd2;
        d_re = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c < 4) chk("wrap_addr", mem_a, wa[c]);
            chk("wrap_ready", 32'(d_ready), 32'(c == 5));
            if (c == 5) d_re = 1'b0;
        end
        @(negedge clk);

        fork
            fetch_port(60);
            data_port(60);
        join
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
